lock_scoreboard: RTL and testbench

LOCK_SCOREBOARD -- requirements
Module: lock_scoreboard

---
 rtl/lock_scoreboard_if.sv | 44 ++++
 rtl/lock_scoreboard.sv | 136 +++++++++++++
 tb/tb_lock_scoreboard.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/lock_scoreboard_if.sv
// Decode/writeback signal bundle for the register lock scoreboard.
// Latency: combinational grouping only, no storage.
// Backpressure: issue_ready is the only stall signal; release and flush are never stalled.
interface lock_scoreboard_if;
    // Decode-side source lookups
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_allow;
    logic       rt_allow;

    // Special-register read requests ([2]=CP0, [1]=HI, [0]=LO)
    logic [2:0] lockreq;
    logic [2:0] lockres;

    // Issue side: destination lock
    logic       issue;
    logic [4:0] lock_rd;
    logic [1:0] lock_aim;
    logic       issue_ready;

    // Writeback side: destination release
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic [1:0] wb_aim;

    // Pipeline kill and status
    logic       flush;
    logic       busy;
    logic       rel_err;

    // Pipeline (decode/writeback) view
    modport master (
        output rs, rt, lockreq, issue, lock_rd, lock_aim,
               wb_valid, wb_rd, wb_aim, flush,
        input  rs_allow, rt_allow, lockres, issue_ready, busy, rel_err
    );

    // Scoreboard view
    modport slave (
        input  rs, rt, lockreq, issue, lock_rd, lock_aim,
               wb_valid, wb_rd, wb_aim, flush,
        output rs_allow, rt_allow, lockres, issue_ready, busy, rel_err
    );
endinterface

// File: rtl/lock_scoreboard.sv
// Pending-write scoreboard: per-register counters of in-flight writes for GPR1..31, HI, LO, CP0.
// Latency: lock/release/flush update counters at the next clk edge; all lookups are combinational from registered counters.
// Backpressure: issue_ready drops when the destination counter is saturated; releases are always accepted.
module lock_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    lock_scoreboard_if.slave  sb
);

    // Counter slot map: slot 0 is GPR0 (never written, always reads zero),
    // slots 1..31 are GPRs, then the three special registers.
    localparam int          NUM_CNT = 35;
    localparam logic [5:0]  IDX_HI  = 6'd32;
    localparam logic [5:0]  IDX_LO  = 6'd33;
    localparam logic [5:0]  IDX_CP0 = 6'd34;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Destination class encoding shared by lock_aim and wb_aim
    localparam logic [1:0] AIM_GPR = 2'b00;
    localparam logic [1:0] AIM_HI  = 2'b10;
    localparam logic [1:0] AIM_LO  = 2'b01;

    logic [CNT_W-1:0] cnt_q [NUM_CNT];
    logic [CNT_W-1:0] cnt_d [NUM_CNT];
    logic             rel_err_q;
    logic             rel_err_d;

    // Map a (class, rd) pair to its counter slot; rd only matters for GPRs,
    // and every CP0 access shares one slot regardless of sel.
    function automatic logic [5:0] tgt_idx(input logic [1:0] aim, input logic [4:0] rd);
        logic [5:0] idx;
        case (aim)
            AIM_GPR: idx = {1'b0, rd};
            AIM_HI:  idx = IDX_HI;
            AIM_LO:  idx = IDX_LO;
            default: idx = IDX_CP0;
        endcase
        return idx;
    endfunction

    logic [5:0]       lock_idx;
    logic [5:0]       wb_idx;
    logic             lock_tgt_vld;
    logic             wb_tgt_vld;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] wb_cnt;
    logic             lock_hit;
    logic             lock_acc;
    logic             rel_acc;
    logic             collide;
    logic             busy_c;

    assign lock_idx     = tgt_idx(sb.lock_aim, sb.lock_rd);
    assign wb_idx       = tgt_idx(sb.wb_aim, sb.wb_rd);
    // GPR0 is a valid encoding but has nothing to track
    assign lock_tgt_vld = (lock_idx != 6'd0);
    assign wb_tgt_vld   = (wb_idx != 6'd0);
    assign lock_cnt     = cnt_q[lock_idx];
    assign wb_cnt       = cnt_q[wb_idx];

    // Slot 0 always reads zero, so GPR0 destinations never stall
    assign sb.issue_ready = (lock_cnt != CNT_MAX);

    // lock_hit ignores issue_ready so that an issue colliding with a release on a
    // saturated counter still cancels it: the count is held rather than decremented.
    assign lock_hit = sb.issue & ~sb.flush & lock_tgt_vld;
    assign lock_acc = lock_hit & sb.issue_ready;
    assign rel_acc  = sb.wb_valid & ~sb.flush & wb_tgt_vld & (wb_cnt != '0);
    assign collide  = lock_hit & rel_acc & (lock_idx == wb_idx);

    // A retire to an idle counter is a protocol error; GPR0 retires are silently ignored
    assign rel_err_d = sb.wb_valid & ~sb.flush & wb_tgt_vld & (wb_cnt == '0);

    // Counter next state: flush clears everything, otherwise apply lock and release,
    // which cancel each other when they land on the same counter.
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (sb.flush) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_d[i] = '0;
            end
        end else if (!collide) begin
            if (lock_acc) begin
                cnt_d[lock_idx] = cnt_q[lock_idx] + CNT_ONE;
            end
            if (rel_acc) begin
                cnt_d[wb_idx] = cnt_q[wb_idx] - CNT_ONE;
            end
        end
        cnt_d[0] = '0;
    end

    // Counter and error-pulse registers; reset wins over flush, lock and release
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
            rel_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            rel_err_q <= rel_err_d;
        end
    end

    // Any outstanding write anywhere keeps the scoreboard busy
    always_comb begin
        busy_c = 1'b0;
        for (int i = 1; i < NUM_CNT; i++) begin
            if (cnt_q[i] != '0) begin
                busy_c = 1'b1;
            end
        end
    end

    // Source lookups see registered counters only: a same-cycle writeback does not bypass
    assign sb.rs_allow = (cnt_q[{1'b0, sb.rs}] == '0);
    assign sb.rt_allow = (cnt_q[{1'b0, sb.rt}] == '0);

    // Unrequested special-register bits always grant
    assign sb.lockres[2] = ~sb.lockreq[2] | (cnt_q[IDX_CP0] == '0);
    assign sb.lockres[1] = ~sb.lockreq[1] | (cnt_q[IDX_HI]  == '0);
    assign sb.lockres[0] = ~sb.lockreq[0] | (cnt_q[IDX_LO]  == '0);

    assign sb.busy    = busy_c;
    assign sb.rel_err = rel_err_q;

endmodule

// File: tb/tb_lock_scoreboard.sv
// Directed bench for lock_scoreboard: reset, GPR lock/release, saturation, specials, flush, error, reset mid-op.
// Latency: checks sampled 1 time unit after the rising edge or after a combinational input change.
// Backpressure: issue_ready is checked directly; no handshaking is modelled.
module tb_lock_scoreboard;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    lock_scoreboard_if sb_if ();

    lock_scoreboard #(.CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset            = 1'b1;
        sb_if.rs         = '0;
        sb_if.rt         = '0;
        sb_if.lockreq    = '0;
        sb_if.issue      = 1'b0;
        sb_if.lock_rd    = '0;
        sb_if.lock_aim   = '0;
        sb_if.wb_valid   = 1'b0;
        sb_if.wb_rd      = '0;
        sb_if.wb_aim     = '0;
        sb_if.flush      = 1'b0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_rs_allow",    32'(sb_if.rs_allow),    32'd1);
        chk("rst_rt_allow",    32'(sb_if.rt_allow),    32'd1);
        chk("rst_lockres",     32'(sb_if.lockres),     32'h7);
        chk("rst_issue_ready", 32'(sb_if.issue_ready), 32'd1);
        chk("rst_busy",        32'(sb_if.busy),        32'd0);
        chk("rst_rel_err",     32'(sb_if.rel_err),     32'd0);

        // Basic lock/release of GPR5
        sb_if.issue = 1'b1; sb_if.lock_rd = 5'd5; sb_if.lock_aim = 2'b00; sb_if.rs = 5'd5;
        tick();
        sb_if.issue = 1'b0;
        #1;
        chk("gpr5_locked",  32'(sb_if.rs_allow), 32'd0);
        chk("gpr5_busy",    32'(sb_if.busy),     32'd1);
        tick();
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd5; sb_if.wb_aim = 2'b00;
        #1;
        chk("gpr5_no_bypass", 32'(sb_if.rs_allow), 32'd0);
        tick();
        sb_if.wb_valid = 1'b0;
        #1;
        chk("gpr5_released", 32'(sb_if.rs_allow), 32'd1);
        chk("gpr5_idle",     32'(sb_if.busy),     32'd0);
        chk("gpr5_no_err",   32'(sb_if.rel_err),  32'd0);

        // Saturation of GPR7
        sb_if.issue = 1'b1; sb_if.lock_rd = 5'd7; sb_if.lock_aim = 2'b00;
        repeat (3) tick();
        sb_if.issue = 1'b0; sb_if.rt = 5'd7;
        #1;
        chk("gpr7_sat_ready", 32'(sb_if.issue_ready), 32'd0);
        chk("gpr7_sat_rt",    32'(sb_if.rt_allow),    32'd0);
        sb_if.issue = 1'b1; sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd7; sb_if.wb_aim = 2'b00;
        tick();
        sb_if.issue = 1'b0; sb_if.wb_valid = 1'b0;
        #1;
        chk("gpr7_collide_hold", 32'(sb_if.issue_ready), 32'd0);
        chk("gpr7_collide_err",  32'(sb_if.rel_err),     32'd0);
        sb_if.wb_valid = 1'b1;
        tick();
        sb_if.wb_valid = 1'b0;
        #1;
        chk("gpr7_unsat_ready", 32'(sb_if.issue_ready), 32'd1);
        sb_if.wb_valid = 1'b1;
        repeat (2) tick();
        sb_if.wb_valid = 1'b0;
        #1;
        chk("gpr7_drained_rt", 32'(sb_if.rt_allow), 32'd1);
        chk("gpr7_drained",    32'(sb_if.busy),     32'd0);

        // Lock GPR2 while releasing GPR1 in the same cycle
        sb_if.issue = 1'b1; sb_if.lock_rd = 5'd1;
        tick();
        sb_if.lock_rd = 5'd2; sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd1;
        tick();
        sb_if.issue = 1'b0; sb_if.wb_valid = 1'b0; sb_if.rs = 5'd1; sb_if.rt = 5'd2;
        #1;
        chk("split_gpr1_free",   32'(sb_if.rs_allow), 32'd1);
        chk("split_gpr2_locked", 32'(sb_if.rt_allow), 32'd0);
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd2;
        tick();
        sb_if.wb_valid = 1'b0;
        #1;
        chk("split_drained", 32'(sb_if.busy), 32'd0);

        // Special registers: HI, then CP0, LO untouched
        sb_if.issue = 1'b1; sb_if.lock_aim = 2'b10; sb_if.lock_rd = 5'd0;
        tick();
        sb_if.issue = 1'b0; sb_if.lockreq = 3'b010;
        #1;
        chk("hi_lockres", 32'(sb_if.lockres), 32'h5);
        sb_if.lockreq = 3'b001;
        #1;
        chk("hi_lo_free", 32'(sb_if.lockres), 32'h7);
        sb_if.issue = 1'b1; sb_if.lock_aim = 2'b11; sb_if.lock_rd = 5'd12;
        tick();
        sb_if.issue = 1'b0; sb_if.lockreq = 3'b111; sb_if.rs = 5'd12;
        #1;
        chk("cp0_lockres",   32'(sb_if.lockres),  32'h1);
        chk("cp0_gpr12_free", 32'(sb_if.rs_allow), 32'd1);
        sb_if.wb_valid = 1'b1; sb_if.wb_aim = 2'b10; sb_if.wb_rd = 5'd0;
        tick();
        sb_if.wb_aim = 2'b11; sb_if.wb_rd = 5'd3;
        tick();
        sb_if.wb_valid = 1'b0; sb_if.wb_aim = 2'b00;
        #1;
        chk("spec_released", 32'(sb_if.lockres), 32'h7);
        chk("spec_idle",     32'(sb_if.busy),    32'd0);
        chk("spec_no_err",   32'(sb_if.rel_err), 32'd0);

        // Flush priority: GPR3=2, HI=1, flush with a lock of GPR9 and a zero-count release
        sb_if.issue = 1'b1; sb_if.lock_aim = 2'b00; sb_if.lock_rd = 5'd3;
        repeat (2) tick();
        sb_if.lock_aim = 2'b10;
        tick();
        sb_if.issue = 1'b0;
        #1;
        chk("pre_flush_busy", 32'(sb_if.busy), 32'd1);
        sb_if.flush = 1'b1; sb_if.issue = 1'b1; sb_if.lock_aim = 2'b00; sb_if.lock_rd = 5'd9;
        sb_if.wb_valid = 1'b1; sb_if.wb_aim = 2'b00; sb_if.wb_rd = 5'd12;
        tick();
        sb_if.flush = 1'b0; sb_if.issue = 1'b0; sb_if.wb_valid = 1'b0;
        sb_if.rs = 5'd3; sb_if.rt = 5'd9; sb_if.lockreq = 3'b111;
        #1;
        chk("flush_busy",    32'(sb_if.busy),     32'd0);
        chk("flush_gpr3",    32'(sb_if.rs_allow), 32'd1);
        chk("flush_gpr9",    32'(sb_if.rt_allow), 32'd1);
        chk("flush_lockres", 32'(sb_if.lockres),  32'h7);
        chk("flush_rel_err", 32'(sb_if.rel_err),  32'd0);

        // Release to an idle counter, then GPR0 handling
        sb_if.lockreq = 3'b000;
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd12; sb_if.wb_aim = 2'b00;
        tick();
        sb_if.wb_valid = 1'b0;
        #1;
        chk("err_pulse",     32'(sb_if.rel_err), 32'd1);
        chk("err_no_change", 32'(sb_if.busy),    32'd0);
        tick();
        chk("err_one_cycle", 32'(sb_if.rel_err), 32'd0);
        sb_if.issue = 1'b1; sb_if.lock_rd = 5'd0; sb_if.lock_aim = 2'b00;
        #1;
        chk("gpr0_ready", 32'(sb_if.issue_ready), 32'd1);
        tick();
        sb_if.issue = 1'b0; sb_if.rs = 5'd0;
        #1;
        chk("gpr0_allow", 32'(sb_if.rs_allow), 32'd1);
        chk("gpr0_busy",  32'(sb_if.busy),     32'd0);
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd0;
        tick();
        sb_if.wb_valid = 1'b0;
        #1;
        chk("gpr0_rel_no_err", 32'(sb_if.rel_err), 32'd0);

        // Reset mid-operation with GPR4=1, a lock and a zero-count release in flight
        sb_if.issue = 1'b1; sb_if.lock_rd = 5'd4; sb_if.lock_aim = 2'b00;
        tick();
        sb_if.issue = 1'b0;
        #1;
        chk("pre_rst_busy", 32'(sb_if.busy), 32'd1);
        reset = 1'b1; sb_if.issue = 1'b1;
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd12;
        tick();
        reset = 1'b0; sb_if.issue = 1'b0; sb_if.wb_valid = 1'b0;
        sb_if.rs = 5'd4; sb_if.rt = 5'd4; sb_if.lockreq = 3'b000;
        #1;
        chk("mid_rst_rs_allow",    32'(sb_if.rs_allow),    32'd1);
        chk("mid_rst_rt_allow",    32'(sb_if.rt_allow),    32'd1);
        chk("mid_rst_lockres",     32'(sb_if.lockres),     32'h7);
        chk("mid_rst_issue_ready", 32'(sb_if.issue_ready), 32'd1);
        chk("mid_rst_busy",        32'(sb_if.busy),        32'd0);
        chk("mid_rst_rel_err",     32'(sb_if.rel_err),     32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
